// File: rtl/fpga_bootrom_arbiter_if.sv
// Bus bundle between the two boot-ROM requesters (instruction / data) and the ROM macro.
// The arbiter takes the slave view; the testbench side drives through master.
interface fpga_bootrom_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROM_AW     = 10
);
  logic                  instr_req_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [DATA_WIDTH-1:0] instr_rdata_o;

  logic                  data_req_i;
  logic                  data_we_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic                  data_err_o;
  logic [DATA_WIDTH-1:0] data_rdata_o;

  logic                  rom_cen_o;
  logic [ROM_AW-1:0]     rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i, data_req_i, data_we_i, data_addr_i, rom_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    output rom_cen_o, rom_addr_o
  );

  modport master (
    output instr_req_i, instr_addr_i, data_req_i, data_we_i, data_addr_i, rom_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    input  rom_cen_o, rom_addr_o
  );
endinterface

// File: rtl/fpga_bootrom_arbiter.sv
// Round-robin arbiter sharing one single-port boot ROM between instruction and data ports.
// Grants are combinational; responses arrive exactly one cycle after the grant.
module fpga_bootrom_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROM_AW     = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  fpga_bootrom_arbiter_if.slave bus
);

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  port_e last_q;
  port_e resp_port_q;
  logic  resp_valid_q;
  logic  resp_err_q;

  logic instr_gnt;
  logic data_gnt;
  logic data_fault;
  logic rom_access;
  logic resp_live;
  logic instr_resp;
  logic data_resp;

  // Only word-address bits reach the ROM; the rest wrap modulo ROM depth.
  logic [ROM_AW-1:0] instr_word;
  logic [ROM_AW-1:0] data_word;
  logic              unused_addr_bits;

  assign instr_word       = bus.instr_addr_i[ROM_AW+1:2];
  assign data_word        = bus.data_addr_i[ROM_AW+1:2];
  assign unused_addr_bits = ^{bus.instr_addr_i[ADDR_WIDTH-1:ROM_AW+2], bus.instr_addr_i[1:0],
                              bus.data_addr_i[ADDR_WIDTH-1:ROM_AW+2]};

  // Under contention the port that did not win last time goes first.
  assign instr_gnt  = rstn && bus.instr_req_i && (!bus.data_req_i || last_q == PORT_DATA);
  assign data_gnt   = rstn && bus.data_req_i && (!bus.instr_req_i || last_q == PORT_INSTR);
  assign data_fault = bus.data_we_i || (bus.data_addr_i[1:0] != 2'b00);
  assign rom_access = instr_gnt || (data_gnt && !data_fault);

  assign bus.instr_gnt_o = instr_gnt;
  assign bus.data_gnt_o  = data_gnt;
  assign bus.rom_cen_o   = !rom_access;
  assign bus.rom_addr_o  = !rom_access ? '0 : (instr_gnt ? instr_word : data_word);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_port_q  <= PORT_INSTR;
      last_q       <= PORT_DATA;
    end else begin
      resp_valid_q <= instr_gnt || data_gnt;
      if (instr_gnt || data_gnt) begin
        resp_port_q <= data_gnt ? PORT_DATA : PORT_INSTR;
        resp_err_q  <= data_gnt && data_fault;
        last_q      <= data_gnt ? PORT_DATA : PORT_INSTR;
      end
    end
  end

  // Responses are also masked while reset is held, before the registers clear.
  assign resp_live  = rstn && resp_valid_q;
  assign instr_resp = resp_live && (resp_port_q == PORT_INSTR);
  assign data_resp  = resp_live && (resp_port_q == PORT_DATA);

  assign bus.instr_rvalid_o = instr_resp;
  assign bus.instr_rdata_o  = (instr_resp && !resp_err_q) ? bus.rom_rdata_i : '0;
  assign bus.data_rvalid_o  = data_resp;
  assign bus.data_err_o     = data_resp && resp_err_q;
  assign bus.data_rdata_o   = (data_resp && !resp_err_q) ? bus.rom_rdata_i : '0;

endmodule

// File: tb/tb_fpga_bootrom_arbiter.sv
// Bench for fpga_bootrom_arbiter: directed scenarios then random traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_fpga_bootrom_arbiter;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ROM_AW     = 10;
  localparam int DEPTH      = 1 << ROM_AW;

  logic clk;
  logic rstn;

  fpga_bootrom_arbiter_if #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ROM_AW(ROM_AW)
  ) bus ();

  fpga_bootrom_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ROM_AW(ROM_AW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM: data for an enabled address appears after the edge; otherwise garbage.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!bus.rom_cen_o) bus.rom_rdata_i <= mem[bus.rom_addr_o];
    else                bus.rom_rdata_i <= $urandom;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model state: who won last contention, and the response owed next cycle.
  int                    last_port  = 1;
  bit                    pend_valid = 0;
  int                    pend_port  = 0;
  bit                    pend_err   = 0;
  logic [DATA_WIDTH-1:0] pend_data  = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL cyc %0d %s: observed %0h expected %0h", cyc, tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit ireq, input logic [31:0] ia,
                       input bit dreq, input bit dwe, input logic [31:0] da);
    bit                    gi, gd, derr, acc;
    int                    word;
    logic [DATA_WIDTH-1:0] exp_irdata, exp_drdata;
    bit                    exp_ivalid, exp_dvalid, exp_derr;
    @(posedge clk);
    #1;
    rstn             = r;
    bus.instr_req_i  = ireq;
    bus.instr_addr_i = ia;
    bus.data_req_i   = dreq;
    bus.data_we_i    = dwe;
    bus.data_addr_i  = da;
    #1;
    cyc++;

    gi = 0;
    gd = 0;
    if (r) begin
      if (ireq && dreq) begin
        if (last_port == 0) gd = 1;
        else                gi = 1;
      end else begin
        gi = ireq;
        gd = dreq;
      end
    end
    derr = gd && (dwe || (da % 4 != 0));
    acc  = gi || (gd && !derr);
    word = !acc ? 0 : (gi ? int'((ia / 4) % DEPTH) : int'((da / 4) % DEPTH));

    exp_ivalid = 0; exp_dvalid = 0; exp_derr = 0;
    exp_irdata = '0; exp_drdata = '0;
    if (r && pend_valid) begin
      if (pend_port == 0) begin
        exp_ivalid = 1;
        exp_irdata = pend_data;
      end else begin
        exp_dvalid = 1;
        exp_derr   = pend_err;
        exp_drdata = pend_err ? '0 : pend_data;
      end
    end

    $display("cyc %0d rstn=%b ireq=%b ia=%h dreq=%b we=%b da=%h -> gi=%b gd=%b rom=%0d",
             cyc, r, ireq, ia, dreq, dwe, da, gi, gd, acc ? word : -1);

    check_val("instr_gnt",    bus.instr_gnt_o,    gi);
    check_val("data_gnt",     bus.data_gnt_o,     gd);
    check_val("rom_cen",      bus.rom_cen_o,      !acc);
    check_val("rom_addr",     bus.rom_addr_o,     word);
    check_val("instr_rvalid", bus.instr_rvalid_o, exp_ivalid);
    check_val("instr_rdata",  bus.instr_rdata_o,  exp_irdata);
    check_val("data_rvalid",  bus.data_rvalid_o,  exp_dvalid);
    check_val("data_err",     bus.data_err_o,     exp_derr);
    check_val("data_rdata",   bus.data_rdata_o,   exp_drdata);

    if (!r) begin
      pend_valid = 0;
      last_port  = 1;
    end else begin
      pend_valid = gi || gd;
      if (gi || gd) begin
        pend_port = gd ? 1 : 0;
        pend_err  = derr;
        pend_data = mem[word];
        last_port = gd ? 1 : 0;
      end
    end
  endtask

  task automatic idle();
    cycle(1, 0, 32'h0, 0, 0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    rstn             = 1'b0;
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_addr_i  = '0;
    bus.rom_rdata_i  = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[2] = 32'h0000_006F;

    // Reset held with requests pending: nothing may be granted.
    repeat (3) cycle(0, 1, 32'h4, 1, 0, 32'h8);

    // First cycle out of reset: instruction fetch of the reset vector.
    cycle(1, 1, 32'h1A00_0008, 0, 0, 32'h0);
    idle();

    // Contention right after reset alternates, instruction first.
    cycle(0, 0, 32'h0, 0, 0, 32'h0);
    repeat (4) cycle(1, 1, 32'h0, 1, 0, 32'h4);
    idle();

    // Data write is an error grant without ROM access.
    cycle(1, 0, 32'h0, 1, 1, 32'h10);
    idle();

    // Misaligned data read wins contention, instruction follows next cycle.
    cycle(1, 1, 32'h40, 0, 0, 32'h0);
    cycle(1, 1, 32'h20, 1, 0, 32'h6);
    cycle(1, 1, 32'h20, 0, 0, 32'h0);
    idle();

    // Address wrap modulo ROM depth.
    cycle(1, 1, 32'h1000, 0, 0, 32'h0);
    idle();

    // Reset right after a grant drops the response; instruction wins afterwards.
    cycle(1, 1, 32'h8, 0, 0, 32'h0);
    cycle(0, 1, 32'h8, 1, 0, 32'h4);
    cycle(1, 1, 32'h0, 1, 0, 32'h4);
    idle();

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(39) != 0), $urandom_range(1), rand_addr(),
            $urandom_range(1), ($urandom_range(5) == 0), rand_addr());
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpga_bootrom_arbiter.md
FPGA_BOOTROM_ARBITER -- requirements
Module: fpga_bootrom_arbiter

Interface
REQ-001: Parameter ADDR_WIDTH, default 32, requester byte-address width.
REQ-002: Parameter DATA_WIDTH, default 32, ROM word width.
REQ-003: Parameter ROM_AW, default 10, ROM word-address width; ROM depth 2^ROM_AW words.
REQ-004: CLK  in  1  single clock, rising edge.
REQ-005: RSTN  in  1  synchronous, active-low reset.
REQ-006: instr_req_i / instr_addr_i  in  1 / ADDR_WIDTH  instruction-port read request, byte address.
REQ-007: instr_gnt_o / instr_rvalid_o  out  1 / 1  instruction-port grant, response valid.
REQ-008: instr_rdata_o  out  DATA_WIDTH  instruction-port read data.
REQ-009: data_req_i / data_we_i / data_addr_i  in  1 / 1 / ADDR_WIDTH  data-port request, write enable, byte address.
REQ-010: data_gnt_o / data_rvalid_o / data_err_o  out  1 / 1 / 1  data-port grant, response valid, error.
REQ-011: data_rdata_o  out  DATA_WIDTH  data-port read data.
REQ-012: rom_cen_o  out  1  ROM chip enable, active-low.
REQ-013: rom_addr_o  out  ROM_AW  ROM word address.
REQ-014: rom_rdata_i  in  DATA_WIDTH  ROM read data, valid the cycle after rom_cen_o low.

Function
REQ-015: Grant combinational, same cycle as request; at most one of instr_gnt_o, data_gnt_o high per cycle.
REQ-016: Single requester: granted unconditionally.
REQ-017: Both requesting: round-robin; winner = port not equal to last_q; last_q := winner on every grant, contended or not.
REQ-018: Granted instruction request, or granted data read with addr[1:0]==0: rom_cen_o=0, rom_addr_o=addr[ROM_AW+1:2]; upper address bits ignored (wrap modulo ROM depth).
REQ-019: No ROM access (rom_cen_o=1, rom_addr_o=0) in cycles without a valid ROM access, including error grants.
REQ-020: Data-port error grant: data_we_i=1 or data_addr_i[1:0]!=0; still granted, no ROM access.
REQ-021: Response registers resp_valid_q, resp_port_q, resp_err_q captured at each grant; fixed latency 1: rvalid of granted port high exactly the cycle after its gnt.
REQ-022: rdata of responding port = rom_rdata_i when no error, 0 when error; rdata of non-responding port = 0.
REQ-023: data_err_o high only together with data_rvalid_o for an error grant; instr port never errors.
REQ-024: Back-to-back grants every cycle supported; no bubbles; throughput 1 access/cycle.
REQ-025: Request/grant of cycle N and response of cycle N-1 coexist without interference.

Reset
REQ-026: RSTN low at a clock edge: resp_valid_q=0, resp_err_q=0, resp_port_q=instr, last_q=data (instruction port wins first contention).
REQ-027: While RSTN low: both gnt outputs 0, rom_cen_o=1, rom_addr_o=0, all rvalid/err/rdata outputs 0.
REQ-028: Reset during an outstanding access (RSTN low the cycle after gnt): response dropped, rvalid stays 0.
REQ-029: First cycle with RSTN high: requests granted normally.

Verification
REQ-030: Instr only, addr 0x1A000008, rom_rdata_i=0x0000006F -> instr_gnt_o=1, rom_cen_o=0, rom_addr_o=2; next cycle instr_rvalid_o=1, instr_rdata_o=0x0000006F.
REQ-031: Both request, addrs 0x0 / 0x4, held 4 cycles after reset -> grants instr, data, instr, data; rom_addr_o 0,1,0,1; each rvalid one cycle after its gnt on correct port.
REQ-032: Data write, addr 0x10 -> data_gnt_o=1, rom_cen_o=1; next cycle data_rvalid_o=1, data_err_o=1, data_rdata_o=0.
REQ-033: Data read addr 0x6 (misaligned) -> granted, no ROM access, next cycle data_err_o=1; instr request same cycle not blocked next cycle.
REQ-034: Instr addr 0x1000 with ROM_AW=10 -> rom_addr_o=0 (wrap).
REQ-035: Grant in cycle N, RSTN low at edge N+1 -> instr_rvalid_o=0 in cycle N+1; after release, contention grants instr first.
